// File: rtl/generic_bus_arbiter.sv
// -----------------------------------------------------------------------------
// generic_bus_arbiter
//
// Shares one memory bus between an instruction requester (i_*) and a data
// requester (d_*). Data requests win by default. An instruction request
// that is being held off is counted in starve_q, and once STARVE_LIMIT data
// grants have gone by, the instruction request gets the next grant. After
// every grant the arbiter spends one IDLE cycle before it grants again.
//
// Ports
//   CLK, nRST                  clock, asynchronous active-low reset
//   i_addr/ren/wen/wdata/byte_en   instruction request (in)
//   i_rdata/busy/error             instruction response (out)
//   d_addr/ren/wen/wdata/byte_en   data request (in)
//   d_rdata/busy/error             data response (out)
//   m_addr/ren/wen/wdata/byte_en   shared memory request (out)
//   m_rdata/busy/error             shared memory response (in)
// -----------------------------------------------------------------------------
module generic_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    // instruction requester
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_ren,
    input  logic              i_wen,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_byte_en,
    output logic [31:0]       i_rdata,
    output logic              i_busy,
    output logic              i_error,
    // data requester
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_byte_en,
    output logic [31:0]       d_rdata,
    output logic              d_busy,
    output logic              d_error,
    // shared memory bus
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_ren,
    output logic              m_wen,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_byte_en,
    input  logic [31:0]       m_rdata,
    input  logic              m_busy,
    input  logic              m_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [7:0] starve_q, starve_d;

    logic i_req;
    logic d_req;

    assign i_req = i_ren | i_wen;
    assign d_req = d_ren | d_wen;

    // State and starvation counter. Because reset is asynchronous and every
    // output is decoded from state_q, asserting nRST drops the bus at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Next-state and starvation bookkeeping
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (d_req && (!i_req || (starve_q < LIMIT_C))) begin
                    state_d = GRANT_D;
                    // Count only the data grants that make i wait.
                    if (i_req && (starve_q < LIMIT_C)) begin
                        starve_d = starve_q + 8'd1;
                    end
                end else if (i_req) begin
                    state_d  = GRANT_I;
                    starve_d = 8'd0;
                end
            end
            GRANT_I: begin
                if (!i_req || !m_busy) begin
                    state_d = IDLE;
                end
            end
            GRANT_D: begin
                if (!d_req || !m_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus multiplexing. The granted requester's fields pass straight through,
    // ren and wen included, so a ren+wen request reaches memory unchanged.
    // If the granted requester drops its request, its busy stays high so it
    // never sees a completion for the abandoned transfer.
    always_comb begin
        m_addr    = '0;
        m_ren     = 1'b0;
        m_wen     = 1'b0;
        m_wdata   = 32'd0;
        m_byte_en = 4'd0;
        i_rdata   = 32'd0;
        i_busy    = 1'b1;
        i_error   = 1'b0;
        d_rdata   = 32'd0;
        d_busy    = 1'b1;
        d_error   = 1'b0;
        case (state_q)
            GRANT_I: begin
                m_addr    = i_addr;
                m_ren     = i_ren;
                m_wen     = i_wen;
                m_wdata   = i_wdata;
                m_byte_en = i_byte_en;
                i_rdata   = m_rdata;
                i_error   = m_error;
                i_busy    = i_req ? m_busy : 1'b1;
            end
            GRANT_D: begin
                m_addr    = d_addr;
                m_ren     = d_ren;
                m_wen     = d_wen;
                m_wdata   = d_wdata;
                m_byte_en = d_byte_en;
                d_rdata   = m_rdata;
                d_error   = m_error;
                d_busy    = d_req ? m_busy : 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_generic_bus_arbiter.sv
module tb_generic_bus_arbiter;

    logic        CLK;
    logic        nRST;
    logic [31:0] i_addr, d_addr, m_addr;
    logic        i_ren, i_wen, d_ren, d_wen, m_ren, m_wen;
    logic [31:0] i_wdata, d_wdata, m_wdata;
    logic [3:0]  i_byte_en, d_byte_en, m_byte_en;
    logic [31:0] i_rdata, d_rdata, m_rdata;
    logic        i_busy, d_busy, m_busy;
    logic        i_error, d_error, m_error;

    int tests;
    int fails;

    generic_bus_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .i_addr(i_addr), .i_ren(i_ren), .i_wen(i_wen), .i_wdata(i_wdata), .i_byte_en(i_byte_en),
        .i_rdata(i_rdata), .i_busy(i_busy), .i_error(i_error),
        .d_addr(d_addr), .d_ren(d_ren), .d_wen(d_wen), .d_wdata(d_wdata), .d_byte_en(d_byte_en),
        .d_rdata(d_rdata), .d_busy(d_busy), .d_error(d_error),
        .m_addr(m_addr), .m_ren(m_ren), .m_wen(m_wen), .m_wdata(m_wdata), .m_byte_en(m_byte_en),
        .m_rdata(m_rdata), .m_busy(m_busy), .m_error(m_error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        i_addr = 0; i_ren = 0; i_wen = 0; i_wdata = 0; i_byte_en = 0;
        d_addr = 0; d_ren = 0; d_wen = 0; d_wdata = 0; d_byte_en = 0;
        m_rdata = 0; m_busy = 1; m_error = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 1'b0;
        #3;
        tests++; if (m_ren !== 1'b0 || m_wen !== 1'b0) begin fails++; $display("FAIL reset_m_rw got ren=%0b wen=%0b want 0 0", m_ren, m_wen); end
        tests++; if (m_addr !== 32'd0 || m_wdata !== 32'd0 || m_byte_en !== 4'd0) begin fails++; $display("FAIL reset_m_fields got addr=%0h wdata=%0h be=%0h want 0", m_addr, m_wdata, m_byte_en); end
        tests++; if (i_busy !== 1'b1 || d_busy !== 1'b1) begin fails++; $display("FAIL reset_busy got i=%0b d=%0b want 1 1", i_busy, d_busy); end
        tests++; if (dut.starve_q !== 8'd0) begin fails++; $display("FAIL reset_starve got %0d want 0", dut.starve_q); end
        @(negedge CLK);
        nRST = 1'b1;
        $display("[TB] reset: done");
    endtask

    task automatic test_idle_hold();
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++; if (m_ren !== 1'b0 || i_busy !== 1'b1 || d_busy !== 1'b1 || i_rdata !== 32'd0) begin fails++; $display("FAIL idle_hold c=%0d got m_ren=%0b i_busy=%0b d_busy=%0b i_rdata=%0h want 0 1 1 0", c, m_ren, i_busy, d_busy, i_rdata); end
        end
        $display("[TB] idle_hold: done");
    endtask

    task automatic test_lone_read();
        i_ren = 1; i_addr = 32'h100; m_busy = 1; m_rdata = 32'h1234_5678;
        #1;
        tests++; if (m_ren !== 1'b0 || i_busy !== 1'b1) begin fails++; $display("FAIL lone_read_pre got m_ren=%0b i_busy=%0b want 0 1", m_ren, i_busy); end
        for (int c = 1; c <= 2; c++) begin
            tick();
            tests++; if (m_ren !== 1'b1 || m_addr !== 32'h100 || i_busy !== 1'b1) begin fails++; $display("FAIL lone_read_wait c=%0d got m_ren=%0b m_addr=%0h i_busy=%0b want 1 100 1", c, m_ren, m_addr, i_busy); end
        end
        tick();
        m_busy = 0;
        #1;
        tests++; if (i_busy !== 1'b0 || i_rdata !== 32'h1234_5678) begin fails++; $display("FAIL lone_read_done got i_busy=%0b i_rdata=%0h want 0 12345678", i_busy, i_rdata); end
        tests++; if (d_busy !== 1'b1 || d_rdata !== 32'd0) begin fails++; $display("FAIL lone_read_d got d_busy=%0b d_rdata=%0h want 1 0", d_busy, d_rdata); end
        tick();
        i_ren = 0;
        tests++; if (m_ren !== 1'b0 || i_busy !== 1'b1 || i_rdata !== 32'd0) begin fails++; $display("FAIL lone_read_idle got m_ren=%0b i_busy=%0b i_rdata=%0h want 0 1 0", m_ren, i_busy, i_rdata); end
        clear_inputs();
        tick();
        $display("[TB] lone_read: done");
    endtask

    task automatic test_contention();
        logic [31:0] exp_addr;
        logic [7:0]  exp_starve;
        i_ren = 1; i_addr = 32'h200; d_ren = 1; d_addr = 32'h300; m_busy = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_addr   = ((k % 5) == 4) ? 32'h200 : 32'h300;
            exp_starve = ((k % 5) == 4) ? 8'd0 : 8'((k % 5) + 1);
            tests++; if (m_ren !== 1'b1 || m_addr !== exp_addr) begin fails++; $display("FAIL contention_grant k=%0d got m_ren=%0b m_addr=%0h want 1 %0h", k, m_ren, m_addr, exp_addr); end
            tests++; if (dut.starve_q !== exp_starve) begin fails++; $display("FAIL contention_starve k=%0d got %0d want %0d", k, dut.starve_q, exp_starve); end
            tests++; if ((exp_addr == 32'h200) ? (i_busy !== 1'b0 || d_busy !== 1'b1) : (d_busy !== 1'b0 || i_busy !== 1'b1)) begin fails++; $display("FAIL contention_busy k=%0d got i_busy=%0b d_busy=%0b", k, i_busy, d_busy); end
            tick();
            tests++; if (m_ren !== 1'b0) begin fails++; $display("FAIL contention_bubble k=%0d got m_ren=%0b want 0", k, m_ren); end
        end
        clear_inputs();
        tick();
        $display("[TB] contention: done");
    endtask

    task automatic test_write_error();
        d_wen = 1; d_addr = 32'h40; d_byte_en = 4'h3; d_wdata = 32'hDEAD_BEEF;
        m_error = 1; m_busy = 0;
        tick();
        tests++; if (m_wen !== 1'b1 || m_ren !== 1'b0 || m_wdata !== 32'hDEAD_BEEF || m_byte_en !== 4'h3) begin fails++; $display("FAIL write_err_bus got wen=%0b ren=%0b wdata=%0h be=%0h want 1 0 deadbeef 3", m_wen, m_ren, m_wdata, m_byte_en); end
        tests++; if (d_error !== 1'b1 || d_busy !== 1'b0) begin fails++; $display("FAIL write_err_d got d_error=%0b d_busy=%0b want 1 0", d_error, d_busy); end
        tests++; if (i_error !== 1'b0 || i_busy !== 1'b1) begin fails++; $display("FAIL write_err_i got i_error=%0b i_busy=%0b want 0 1", i_error, i_busy); end
        tick();
        d_wen = 0;
        tests++; if (d_error !== 1'b0 || d_busy !== 1'b1 || m_wen !== 1'b0) begin fails++; $display("FAIL write_err_after got d_error=%0b d_busy=%0b m_wen=%0b want 0 1 0", d_error, d_busy, m_wen); end
        clear_inputs();
        tick();
        $display("[TB] write_error: done");
    endtask

    task automatic test_rw_both();
        i_ren = 1; i_wen = 1; i_addr = 32'h80; i_byte_en = 4'hF; i_wdata = 32'hA5A5_0001; m_busy = 0;
        tick();
        tests++; if (m_ren !== 1'b1 || m_wen !== 1'b1 || m_addr !== 32'h80 || m_wdata !== 32'hA5A5_0001 || m_byte_en !== 4'hF) begin fails++; $display("FAIL rw_both got ren=%0b wen=%0b addr=%0h wdata=%0h be=%0h want 1 1 80 a5a50001 f", m_ren, m_wen, m_addr, m_wdata, m_byte_en); end
        tick();
        clear_inputs();
        tick();
        $display("[TB] rw_both: done");
    endtask

    task automatic test_withdraw();
        d_ren = 1; d_addr = 32'h600; m_busy = 1;
        tick();
        tests++; if (m_ren !== 1'b1 || m_addr !== 32'h600 || d_busy !== 1'b1) begin fails++; $display("FAIL withdraw_grant got m_ren=%0b m_addr=%0h d_busy=%0b want 1 600 1", m_ren, m_addr, d_busy); end
        d_ren = 0;
        #1;
        tests++; if (m_ren !== 1'b0 || d_busy !== 1'b1) begin fails++; $display("FAIL withdraw_drop got m_ren=%0b d_busy=%0b want 0 1", m_ren, d_busy); end
        m_busy = 0;
        #1;
        tests++; if (d_busy !== 1'b1) begin fails++; $display("FAIL withdraw_nocompl got d_busy=%0b want 1", d_busy); end
        m_busy = 1;
        tick();
        tests++; if (m_ren !== 1'b0 || d_busy !== 1'b1 || dut.state_q !== 2'd0) begin fails++; $display("FAIL withdraw_idle got m_ren=%0b d_busy=%0b state=%0d want 0 1 0", m_ren, d_busy, dut.state_q); end
        clear_inputs();
        tick();
        $display("[TB] withdraw: done");
    endtask

    task automatic test_reset_mid_grant();
        i_ren = 1; i_addr = 32'h400; m_busy = 1;
        tick();
        tests++; if (m_ren !== 1'b1 || m_addr !== 32'h400) begin fails++; $display("FAIL rstmid_grant got m_ren=%0b m_addr=%0h want 1 400", m_ren, m_addr); end
        nRST = 1'b0;
        #1;
        tests++; if (m_ren !== 1'b0 || m_addr !== 32'd0 || i_busy !== 1'b1) begin fails++; $display("FAIL rstmid_abort got m_ren=%0b m_addr=%0h i_busy=%0b want 0 0 1", m_ren, m_addr, i_busy); end
        d_ren = 1; d_addr = 32'h500;
        tick();
        tests++; if (m_ren !== 1'b0 || i_busy !== 1'b1 || d_busy !== 1'b1) begin fails++; $display("FAIL rstmid_held got m_ren=%0b i_busy=%0b d_busy=%0b want 0 1 1", m_ren, i_busy, d_busy); end
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        tests++; if (m_ren !== 1'b1 || m_addr !== 32'h500 || i_busy !== 1'b1) begin fails++; $display("FAIL rstmid_dfirst got m_ren=%0b m_addr=%0h i_busy=%0b want 1 500 1", m_ren, m_addr, i_busy); end
        tests++; if (dut.starve_q !== 8'd1) begin fails++; $display("FAIL rstmid_starve got %0d want 1", dut.starve_q); end
        clear_inputs();
        tick();
        tick();
        $display("[TB] reset_mid_grant: done");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_idle_hold();
        test_lone_read();
        test_contention();
        test_write_error();
        test_rw_both();
        test_withdraw();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
